// File: rtl/misr_pkg.sv
// Shared constants for the MISR response checker: FSM encoding and default
// feedback polynomial / seed.
package misr_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StCheck = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [3:0] DefPoly = 4'b1010;
    localparam logic [3:0] DefSeed = 4'b0000;

    localparam int unsigned CountW = 4;

endpackage

// File: rtl/misr_checker_if.sv
// Control/response bundle of misr_checker; slave is the checker, master the driver.
interface misr_checker_if #(
    parameter int unsigned W  = 3,
    parameter int unsigned SW = 4
);
    logic          start;
    logic [W-1:0]  din;
    logic          din_valid;
    logic [SW-1:0] golden;
    logic          busy;
    logic          done;
    logic          pass;
    logic [SW-1:0] signature;
    logic [3:0]    count;

    modport slave (
        input  start, din, din_valid, golden,
        output busy, done, pass, signature, count
    );

    modport master (
        output start, din, din_valid, golden,
        input  busy, done, pass, signature, count
    );
endinterface

// File: rtl/misr_core.sv
// Signature register with multiple-input shift-register compaction; load
// reseeds, en compacts one sample.
module misr_core
    import misr_pkg::*;
#(
    parameter int unsigned    W    = 3,
    parameter int unsigned    SW   = 4,
    parameter logic [SW-1:0]  POLY = SW'(DefPoly),
    parameter logic [SW-1:0]  SEED = SW'(DefSeed)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    input  logic [W-1:0]  din,
    output logic [SW-1:0] sig
);

    logic [SW-1:0] sig_q, sig_d, din_ext;
    logic          fb;

    always_comb begin
        // Bits at or above W see no response input.
        din_ext = '0;
        din_ext[W-1:0] = din;
        fb = sig_q[SW-1];
        sig_d = '0;
        sig_d[0] = fb ^ din_ext[0];
        for (int i = 1; i < SW; i++) begin
            sig_d[i] = sig_q[i-1] ^ (POLY[i] & fb) ^ din_ext[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || load) begin
            sig_q <= SEED;
        end else if (en) begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/misr_checker.sv
// Run controller: compacts N_PATTERNS valid samples, then compares the
// signature against golden once and holds the verdict until restarted.
module misr_checker
    import misr_pkg::*;
#(
    parameter int unsigned   W          = 3,
    parameter int unsigned   SW         = 4,
    parameter logic [SW-1:0] POLY       = SW'(DefPoly),
    parameter logic [SW-1:0] SEED       = SW'(DefSeed),
    parameter int unsigned   N_PATTERNS = 15
) (
    input  logic           clk,
    input  logic           rst,
    misr_checker_if.slave  bus
);

    localparam logic [CountW-1:0] NPat = CountW'(N_PATTERNS);

    logic [1:0]        state_q, state_d;
    logic [CountW-1:0] count_q, count_d;
    logic              pass_q, pass_d;
    logic              load, en;
    logic [SW-1:0]     sig;

    misr_core #(
        .W    (W),
        .SW   (SW),
        .POLY (POLY),
        .SEED (SEED)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .en   (en),
        .din  (bus.din),
        .sig  (sig)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pass_d  = pass_q;
        load    = 1'b0;
        en      = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                // A concurrent din_valid is dropped: start only reseeds.
                if (bus.start) begin
                    state_d = StRun;
                    count_d = '0;
                    pass_d  = 1'b0;
                    load    = 1'b1;
                end
            end
            StRun: begin
                if (bus.din_valid) begin
                    en      = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q + 1'b1 == NPat) begin
                        state_d = StCheck;
                    end
                end
            end
            StCheck: begin
                pass_d  = (sig == bus.golden);
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.busy      = (state_q == StRun) || (state_q == StCheck);
    assign bus.done      = (state_q == StDone);
    assign bus.pass      = pass_q;
    assign bus.signature = sig;
    assign bus.count     = count_q;

endmodule

// File: doc/misr_checker.md
MISR_CHECKER -- requirements
Module: misr_checker

Interface
REQ-001 The block SHALL have parameter W, default 3, giving the response input width.
REQ-002 The block SHALL have parameter SW, default 4, giving the signature width; W <= SW SHALL hold.
REQ-003 The block SHALL have parameter POLY, default 4'b1010, where bit i (i >= 1) feeds sig[SW-1] into bit i.
REQ-004 The block SHALL have parameter SEED, default 4'b0000, giving the signature initial value.
REQ-005 The block SHALL have parameter N_PATTERNS, default 15, giving the number of samples compacted per run.
REQ-006 Port clk, input, 1 bit: the single clock, rising edge active.
REQ-007 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 Port start, input, 1 bit: begins a run when sampled in IDLE or DONE.
REQ-009 Port din, input, W bits: circuit-under-test response sample.
REQ-010 Port din_valid, input, 1 bit: din is accepted on this edge.
REQ-011 Port golden, input, SW bits: expected signature, sampled in CHECK.
REQ-012 Port busy, output, 1 bit: high in RUN and CHECK.
REQ-013 Port done, output, 1 bit: high in DONE.
REQ-014 Port pass, output, 1 bit: comparison result, meaningful only while done = 1.
REQ-015 Port signature, output, SW bits: current signature register.
REQ-016 Port count, output, 4 bits: number of samples accepted in the current run.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN, CHECK and DONE.
REQ-018 IDLE SHALL go to RUN when start = 1; on that edge signature SHALL load SEED and count SHALL clear to 0.
REQ-019 In RUN, each edge with din_valid = 1 SHALL update the signature and increment count; edges with din_valid = 0 SHALL hold both.
REQ-020 Signature update, with fb = sig[SW-1]:
- next[0] = fb ^ din[0]
- next[i] = sig[i-1] ^ (POLY[i] & fb) ^ din[i] for i < W
- din terms are 0 for i >= W
REQ-021 The accepted sample that brings count to N_PATTERNS SHALL move the FSM to CHECK on the same edge.
REQ-022 CHECK SHALL last exactly one cycle, register pass = (signature == golden), and go to DONE.
- done and pass are therefore valid on the second rising edge after the final accepted sample.
REQ-023 In CHECK and DONE, din_valid SHALL be ignored and signature SHALL hold.
REQ-024 DONE SHALL hold done, pass and signature until start = 1, which SHALL restart as in REQ-018 and clear pass and done.
REQ-025 start asserted in RUN or CHECK SHALL be ignored.
REQ-026 start and din_valid both high in IDLE or DONE: the block SHALL reseed only and SHALL NOT compact the sample.
REQ-027 count SHALL never exceed N_PATTERNS and SHALL NOT wrap.

Reset
REQ-028 rst = 1 on a rising edge SHALL force state IDLE, signature = SEED, count = 0, and busy = done = pass = 0.
REQ-029 rst SHALL take priority over start and din_valid, including mid-run, and SHALL abort the run without any partial pass/done output.

Structure
REQ-030 The state encoding and the default POLY and SEED constants SHALL reside in shared package misr_pkg.
REQ-031 The signature register plus the update logic of REQ-020 SHALL be one sub-module, misr_core, with clk, rst, load, en, din and sig ports.
REQ-032 The FSM, the counter and the compare logic SHALL reside in misr_checker.

Verification
REQ-033 Single-sample compaction: N_PATTERNS=1, SEED=0000, start, then din=101 valid -> signature=0101; with golden=0101, done=1 and pass=1 two edges after the sample.
REQ-034 Multi-sample compaction: N_PATTERNS=3, SEED=0, din 101, 000, 000 -> signature 0101, 1010, 1111; golden=1111 -> pass=1; golden=1110 -> pass=0.
REQ-035 Gaps in valid: N_PATTERNS=3, valid samples separated by din_valid=0 cycles -> same 1111 result; count steps 0, 1, 2, 3 only on valid edges.
REQ-036 Reset mid-run: rst=1 after 2 of 15 samples -> next edge state IDLE, signature=SEED, count=0, done=0, busy=0.
REQ-037 Restart and ignored input: start in DONE -> busy=1, count=0, signature=SEED, pass=0; start pulsed in RUN -> no effect on count or signature.
REQ-038 Full default run: 15 samples taken from the 4-bit LFSR pattern generator's output, passed through the existing minimization logic -> final signature matches the value computed by the bench model, and pass=1.
